// File: rtl/decimating_averager.sv
// ---------------------------------------------------------------------------
// decimating_averager
// Boxcar-averages exactly 2^OSR_LOG2 unsigned ADC samples per output word and
// presents the decimated result on a valid/ready handshake. The sub-sample
// strobe is either an internal timebase (one strobe every
// SAMPLE_COUNT >> OSR_LOG2 clocks) or the ADC's own data-valid, selected at
// run time. Results overwritten before they are consumed set a sticky overrun.
//
// Build option: define DECIMATING_AVERAGER_ROUND_EN for round-half-up
// averaging; otherwise the average is truncated.
//
// Ports:
//   clk_100mhz      system clock
//   rst_n           asynchronous active-low reset
//   enable          run; low aborts the partial window
//   use_ext_strobe  0 = internal timer strobe, 1 = data_in_valid strobe
//   data_in         unsigned ADC sample
//   data_in_valid   external sample strobe (external mode only)
//   out_data        averaged sample
//   out_valid       out_data holds an unconsumed result
//   out_ready       consumer accepts out_data when out_valid & out_ready
//   sample_trigger  one-cycle pulse on the cycle a new result is loaded
//   overrun         sticky: an unconsumed result was overwritten
//   clear_overrun   clears overrun (a simultaneous new overrun wins)
// ---------------------------------------------------------------------------
module decimating_averager #(
   parameter int unsigned DATA_W       = 12,
   parameter int unsigned OSR_LOG2     = 6,
   parameter int unsigned SAMPLE_COUNT = 33280
) (
   input  logic              clk_100mhz,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              use_ext_strobe,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_in_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sample_trigger,
   output logic              overrun,
   input  logic              clear_overrun
);

   // Accumulator holds 2^OSR_LOG2 full-scale samples without overflow.
   localparam int unsigned ACC_W  = DATA_W + OSR_LOG2;
   localparam int unsigned PERIOD = SAMPLE_COUNT >> OSR_LOG2;
   localparam int unsigned TMR_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(PERIOD - 1);
   localparam logic [OSR_LOG2-1:0] SUB_LAST = '1;

`ifdef DECIMATING_AVERAGER_ROUND_EN
   // Half an LSB of the output; the sum plus bias still fits in ACC_W bits.
   localparam logic [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) << (OSR_LOG2 - 1);
`endif

   logic [ACC_W-1:0]    acc_q;
   logic [ACC_W-1:0]    acc_d;
   logic [OSR_LOG2-1:0] sub_q;
   logic [OSR_LOG2-1:0] sub_d;
   logic [TMR_W-1:0]    tmr_q;
   logic [TMR_W-1:0]    tmr_d;
   logic                mode_q;
   logic [DATA_W-1:0]   data_d;
   logic                valid_d;
   logic                trig_d;
   logic                ovr_d;

   logic                abort_c;
   logic                strobe_c;
   logic                take_c;
   logic                load_c;
   logic [ACC_W-1:0]    sum_c;
   logic [ACC_W-1:0]    res_c;

   // Next-state logic for the window, timebase and output handshake.
   always_comb begin
      acc_d   = acc_q;
      sub_d   = sub_q;
      tmr_d   = tmr_q;
      data_d  = out_data;
      valid_d = out_valid && !out_ready;
      trig_d  = 1'b0;
      ovr_d   = overrun;

      // A mode change is treated exactly like enable low for one cycle.
      abort_c  = !enable || (use_ext_strobe != mode_q);
      strobe_c = use_ext_strobe ? data_in_valid : (tmr_q == TMR_LAST);
      take_c   = strobe_c && !abort_c;
      load_c   = take_c && (sub_q == SUB_LAST);
      sum_c    = acc_q + ACC_W'(data_in);
`ifdef DECIMATING_AVERAGER_ROUND_EN
      res_c    = sum_c + ROUND_BIAS;
`else
      res_c    = sum_c;
`endif

      // Timebase runs only in internal mode while not aborted.
      if (abort_c || use_ext_strobe) begin
         tmr_d = '0;
      end else if (tmr_q == TMR_LAST) begin
         tmr_d = '0;
      end else begin
         tmr_d = tmr_q + TMR_W'(1);
      end

      if (abort_c || load_c) begin
         acc_d = '0;
         sub_d = '0;
      end else if (take_c) begin
         acc_d = sum_c;
         sub_d = sub_q + OSR_LOG2'(1);
      end

      if (load_c) begin
         data_d  = DATA_W'(res_c >> OSR_LOG2);
         valid_d = 1'b1;
         trig_d  = 1'b1;
      end

      // Overwrite of an unconsumed result sets overrun; set beats clear.
      if (load_c && out_valid && !out_ready) begin
         ovr_d = 1'b1;
      end else if (clear_overrun) begin
         ovr_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         acc_q          <= '0;
         sub_q          <= '0;
         tmr_q          <= '0;
         mode_q         <= 1'b0;
         out_data       <= '0;
         out_valid      <= 1'b0;
         sample_trigger <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         acc_q          <= acc_d;
         sub_q          <= sub_d;
         tmr_q          <= tmr_d;
         mode_q         <= use_ext_strobe;
         out_data       <= data_d;
         out_valid      <= valid_d;
         sample_trigger <= trig_d;
         overrun        <= ovr_d;
      end
   end

endmodule
